// File: rtl/ysyx_pkg.sv
// Shared types and derived widths for the ysyx L1 instruction cache.
`include "ysyx.svh"

package ysyx_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } l1i_state_e;

    // Tag is whatever remains above the index, word offset and byte offset.
    function automatic int l1i_tag_w(input int xlen, input int idx_len, input int line_len);
        return xlen - idx_len - line_len - 2;
    endfunction

    localparam int L1I_IDX_W = `YSYX_L1I_LEN;
    localparam int L1I_OFS_W = `YSYX_L1I_LINE_LEN;
    localparam int L1I_TAG_W = l1i_tag_w(`YSYX_XLEN, `YSYX_L1I_LEN, `YSYX_L1I_LINE_LEN);
endpackage

// File: rtl/ysyx.svh
// Default geometry for the ysyx L1 instruction cache.
`ifndef YSYX_SVH
`define YSYX_SVH
`define YSYX_XLEN 32
`define YSYX_L1I_LEN 4
`define YSYX_L1I_LINE_LEN 2
`endif

// File: rtl/ysyx_l1i_array.sv
// Data and tag storage: asynchronous read for zero-cycle hits, synchronous write.
module ysyx_l1i_array
    import ysyx_pkg::*;
#(
    parameter int IDX_W = L1I_IDX_W,
    parameter int OFS_W = L1I_OFS_W,
    parameter int TAG_W = L1I_TAG_W
) (
    input  logic             clock,
    input  logic             data_we,
    input  logic [IDX_W-1:0] w_idx,
    input  logic [OFS_W-1:0] w_ofs,
    input  logic [31:0]      w_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] w_tag,
    input  logic [IDX_W-1:0] r_idx,
    input  logic [OFS_W-1:0] r_ofs,
    output logic [31:0]      r_data,
    output logic [TAG_W-1:0] r_tag
);
    logic [31:0]      data_mem [2**(IDX_W+OFS_W)];
    logic [TAG_W-1:0] tag_mem  [2**IDX_W];

    always_ff @(posedge clock) begin
        if (data_we) data_mem[{w_idx, w_ofs}] <= w_data;
        if (tag_we)  tag_mem[w_idx] <= w_tag;
    end

    assign r_data = data_mem[{r_idx, r_ofs}];
    assign r_tag  = tag_mem[r_idx];
endmodule

// File: rtl/ysyx_l1i.sv
// Direct-mapped, blocking L1 instruction cache with whole-line burst refill.
`include "ysyx.svh"

module ysyx_l1i
    import ysyx_pkg::*;
#(
    parameter int XLEN         = `YSYX_XLEN,
    parameter int L1I_LEN      = `YSYX_L1I_LEN,
    parameter int L1I_LINE_LEN = `YSYX_L1I_LINE_LEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] ifu_pc,
    input  logic            ifu_invalid,
    output logic [31:0]     ifu_inst,
    output logic            ifu_valid,
    output logic            bus_arvalid,
    output logic [XLEN-1:0] bus_araddr,
    input  logic            bus_rready,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_rvalid,
    input  logic            bus_rlast
);
    localparam int OFS_W   = L1I_LINE_LEN;
    localparam int IDX_W   = L1I_LEN;
    localparam int TAG_W   = l1i_tag_w(XLEN, L1I_LEN, L1I_LINE_LEN);
    localparam int IDX_LSB = OFS_W + 2;
    localparam int TAG_LSB = OFS_W + 2 + IDX_W;

    l1i_state_e          state_q, state_d;
    logic [2**IDX_W-1:0] valid_q, valid_d;
    logic [OFS_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                drop_q, drop_d;
    logic                arvalid_q, arvalid_d;
    logic [XLEN-1:0]     araddr_q, araddr_d;

    logic [OFS_W-1:0] pc_ofs;
    logic [IDX_W-1:0] pc_idx, lat_idx;
    logic [TAG_W-1:0] pc_tag, lat_tag, rd_tag;
    logic [31:0]      rd_data;
    logic             hit, data_we, tag_we, pc_unused;

    assign pc_ofs    = ifu_pc[IDX_LSB-1:2];
    assign pc_idx    = ifu_pc[TAG_LSB-1:IDX_LSB];
    assign pc_tag    = ifu_pc[XLEN-1:TAG_LSB];
    assign pc_unused = ^ifu_pc[1:0];
    // The refill always targets the latched line address, whatever pc does meanwhile.
    assign lat_idx   = araddr_q[TAG_LSB-1:IDX_LSB];
    assign lat_tag   = araddr_q[XLEN-1:TAG_LSB];

    ysyx_l1i_array #(
        .IDX_W(IDX_W),
        .OFS_W(OFS_W),
        .TAG_W(TAG_W)
    ) u_array (
        .clock  (clock),
        .data_we(data_we),
        .w_idx  (lat_idx),
        .w_ofs  (beat_cnt_q),
        .w_data (bus_rdata[31:0]),
        .tag_we (tag_we),
        .w_tag  (lat_tag),
        .r_idx  (pc_idx),
        .r_ofs  (pc_ofs),
        .r_data (rd_data),
        .r_tag  (rd_tag)
    );

    assign hit         = (state_q == IDLE) && valid_q[pc_idx] && (rd_tag == pc_tag);
    assign ifu_valid   = hit && !ifu_invalid;
    assign ifu_inst    = rd_data;
    assign bus_arvalid = arvalid_q;
    assign bus_araddr  = araddr_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        beat_cnt_d = beat_cnt_q;
        drop_d     = drop_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ifu_invalid && !hit) begin
                    araddr_d  = {pc_tag, pc_idx, {(OFS_W + 2){1'b0}}};
                    arvalid_d = 1'b1;
                    state_d   = AR;
                end
            end
            AR: begin
                if (bus_rready) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = R;
                end
            end
            R: begin
                if (bus_rvalid) begin
                    data_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + OFS_W'(1);
                    if (bus_rlast) begin
                        tag_we  = 1'b1;
                        if (!drop_q) valid_d[lat_idx] = 1'b1;
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over a fill completing on the same edge; an ongoing burst is marked to drop.
        if (ifu_invalid) begin
            valid_d = '0;
            if (state_q != IDLE && state_d != IDLE) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            beat_cnt_q <= '0;
            drop_q     <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            beat_cnt_q <= beat_cnt_d;
            drop_q     <= drop_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
        end
    end
endmodule

// File: tb/tb_ysyx_l1i.sv
// Self-checking bench for ysyx_l1i: directed scenarios plus a randomized run against a cache model.
`timescale 1ns/1ps

module tb_ysyx_l1i;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifu_pc;
    logic        ifu_invalid;
    logic [31:0] ifu_inst;
    logic        ifu_valid;
    logic        bus_arvalid;
    logic [31:0] bus_araddr;
    logic        bus_rready;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        bus_rlast;

    int total = 0;
    int bad   = 0;

    ysyx_l1i #(
        .XLEN(32),
        .L1I_LEN(4),
        .L1I_LINE_LEN(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ifu_pc     (ifu_pc),
        .ifu_invalid(ifu_invalid),
        .ifu_inst   (ifu_inst),
        .ifu_valid  (ifu_valid),
        .bus_arvalid(bus_arvalid),
        .bus_araddr (bus_araddr),
        .bus_rready (bus_rready),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .bus_rlast  (bus_rlast)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Backing memory content used by the randomized run.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    // Bus slave for one refill: waits for the request, delays the AR handshake, then
    // sends four beats (beat 0 in the low word) with random gaps. Only observes, never judges.
    task automatic serve_refill(input logic [127:0] beats, input int inv_beat, input int rdy_delay,
                                output logic [31:0] addr_seen, output bit held,
                                output bit valid_seen, output bit timeout);
        int n;
        held = 1'b1;
        valid_seen = 1'b0;
        timeout = 1'b0;
        addr_seen = '0;
        n = 0;
        while (bus_arvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (bus_arvalid !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        addr_seen = bus_araddr;
        for (int i = 0; i < rdy_delay; i++) begin
            tick();
            if (bus_arvalid !== 1'b1 || bus_araddr !== addr_seen) held = 1'b0;
            if (ifu_valid !== 1'b0) valid_seen = 1'b1;
        end
        bus_rready = 1'b1;
        tick();
        bus_rready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 1) == 1) tick();
            if (ifu_valid !== 1'b0) valid_seen = 1'b1;
            bus_rvalid  = 1'b1;
            bus_rdata   = beats[b*32 +: 32];
            bus_rlast   = (b == 3);
            ifu_invalid = (b == inv_beat);
            tick();
            bus_rvalid  = 1'b0;
            bus_rlast   = 1'b0;
            ifu_invalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifu_pc = 32'h8000_0008;
        ifu_invalid = 1'b0;
        bus_rready = 1'b0;
        bus_rdata = '0;
        bus_rvalid = 1'b0;
        bus_rlast = 1'b0;
        #3;
        total++; if (bus_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b want=0", bus_arvalid); end
        total++; if (bus_araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h want=0", bus_araddr); end
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL reset_ifu_valid got=%b want=0", ifu_valid); end
        repeat (2) @(posedge clock);
        #1;
        ifu_invalid = 1'b1;
        reset = 1'b1;
        tick();
        total++; if (bus_arvalid !== 1'b0) begin bad++; $display("FAIL reset_invalid_no_miss got=%b want=0", bus_arvalid); end
        ifu_invalid = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_cold_miss();
        logic [31:0] a; bit h, v, t;
        ifu_pc = 32'h8000_0008;
        #1;
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL cold_lookup got=%b want=0", ifu_valid); end
        serve_refill({32'h44, 32'h33, 32'h22, 32'h11}, -1, 3, a, h, v, t);
        total++; if (t) begin bad++; $display("FAIL cold_timeout got=no_request want=request"); end
        total++; if (a !== 32'h8000_0000) begin bad++; $display("FAIL cold_araddr got=%h want=80000000", a); end
        total++; if (!h) begin bad++; $display("FAIL cold_ar_hold got=dropped want=held"); end
        total++; if (v) begin bad++; $display("FAIL cold_valid_in_fill got=1 want=0"); end
        total++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h33) begin
            bad++; $display("FAIL cold_after_fill got=%b/%h want=1/00000033", ifu_valid, ifu_inst); end
        $display("cold_miss: pc=%h araddr=%h inst=%h", ifu_pc, a, ifu_inst);
    endtask

    task automatic test_hit();
        ifu_pc = 32'h8000_000C;
        #1;
        total++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h44) begin
            bad++; $display("FAIL hit got=%b/%h want=1/00000044", ifu_valid, ifu_inst); end
        tick();
        total++; if (bus_arvalid !== 1'b0) begin bad++; $display("FAIL hit_no_request got=%b want=0", bus_arvalid); end
        $display("hit: pc=%h inst=%h", ifu_pc, ifu_inst);
    endtask

    task automatic test_conflict();
        logic [31:0] a; bit h, v, t;
        ifu_pc = 32'h8000_0108;
        #1;
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL conflict_lookup got=%b want=0", ifu_valid); end
        serve_refill({32'hD4, 32'hC3, 32'hB2, 32'hA1}, -1, 1, a, h, v, t);
        total++; if (t || a !== 32'h8000_0100) begin bad++; $display("FAIL conflict_araddr got=%h want=80000100", a); end
        total++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'hC3) begin
            bad++; $display("FAIL conflict_fill got=%b/%h want=1/000000c3", ifu_valid, ifu_inst); end
        ifu_pc = 32'h8000_0008;
        #1;
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL conflict_evicted got=%b want=0", ifu_valid); end
        serve_refill({32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, a, h, v, t);
        total++; if (t || a !== 32'h8000_0000) begin bad++; $display("FAIL conflict_refetch got=%h want=80000000", a); end
        $display("conflict: second araddr=%h", a);
    endtask

    task automatic test_invalidate();
        logic [31:0] a; bit h, v, t;
        ifu_pc = 32'h8000_000C;
        #1;
        total++; if (ifu_valid !== 1'b1) begin bad++; $display("FAIL inv_pre_hit got=%b want=1", ifu_valid); end
        ifu_invalid = 1'b1;
        #1;
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL inv_forces_low got=%b want=0", ifu_valid); end
        tick();
        ifu_invalid = 1'b0;
        total++; if (bus_arvalid !== 1'b0) begin bad++; $display("FAIL inv_no_miss got=%b want=0", bus_arvalid); end
        #1;
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL inv_line_gone got=%b want=0", ifu_valid); end
        tick();
        total++; if (bus_arvalid !== 1'b1) begin bad++; $display("FAIL inv_miss_request got=%b want=1", bus_arvalid); end
        serve_refill({32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, a, h, v, t);
        $display("invalidate: refill araddr=%h", a);
    endtask

    task automatic test_invalidate_mid_burst();
        logic [31:0] a; bit h, v, t;
        ifu_pc = 32'h8000_0044;
        serve_refill({32'h4, 32'h3, 32'h2, 32'h1}, 2, 1, a, h, v, t);
        total++; if (t || a !== 32'h8000_0040) begin bad++; $display("FAIL midinv_araddr got=%h want=80000040", a); end
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL midinv_dropped got=%b want=0", ifu_valid); end
        tick();
        total++; if (bus_arvalid !== 1'b1) begin bad++; $display("FAIL midinv_remiss got=%b want=1", bus_arvalid); end
        serve_refill({32'h8, 32'h7, 32'h6, 32'h5}, -1, 0, a, h, v, t);
        total++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h6) begin
            bad++; $display("FAIL midinv_refill got=%b/%h want=1/00000006", ifu_valid, ifu_inst); end
        $display("invalidate_mid_burst: final inst=%h", ifu_inst);
    endtask

    task automatic test_reset_mid_r();
        logic [31:0] a; bit h, v, t;
        ifu_pc = 32'h8000_0080;
        tick();
        total++; if (bus_arvalid !== 1'b1) begin bad++; $display("FAIL rstr_request got=%b want=1", bus_arvalid); end
        bus_rready = 1'b1;
        tick();
        bus_rready = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hDEAD;
        tick();
        bus_rvalid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus_arvalid !== 1'b0 || ifu_valid !== 1'b0) begin
            bad++; $display("FAIL rstr_async got=%b/%b want=0/0", bus_arvalid, ifu_valid); end
        total++; if (bus_araddr !== 32'h0) begin bad++; $display("FAIL rstr_araddr got=%h want=0", bus_araddr); end
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total++; if (ifu_valid !== 1'b0) begin bad++; $display("FAIL rstr_first_miss got=%b want=0", ifu_valid); end
        serve_refill({32'hF4, 32'hF3, 32'hF2, 32'hF1}, -1, 0, a, h, v, t);
        ifu_pc = 32'h8000_0080;
        #1;
        total++; if (t || ifu_valid !== 1'b1 || ifu_inst !== 32'hF1) begin
            bad++; $display("FAIL rstr_refill got=%b/%h want=1/000000f1", ifu_valid, ifu_inst); end
        $display("reset_mid_r: araddr=%h inst=%h", a, ifu_inst);
    endtask

    // Model: one (valid, tag) per index; data is implied by mem_word of the fetch address.
    task automatic test_random();
        bit          mv [16];
        logic [23:0] mt [16];
        logic [31:0] pc, a, line;
        bit          h, v, t, exp_hit, inv;
        int          idx, inv_beat, nmiss;
        ifu_invalid = 1'b1;
        tick();
        ifu_invalid = 1'b0;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        nmiss = 0;
        for (int it = 0; it < 300; it++) begin
            pc = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4)
                 | (32'($urandom_range(0, 3)) << 2);
            idx = int'(pc[7:4]);
            line = {pc[31:4], 4'h0};
            inv = ($urandom_range(0, 19) == 0);
            ifu_pc = pc;
            ifu_invalid = inv;
            #1;
            exp_hit = !inv && mv[idx] && (mt[idx] == pc[31:8]);
            total++; if (ifu_valid !== exp_hit) begin
                bad++; $display("FAIL rand_valid pc=%h got=%b want=%b", pc, ifu_valid, exp_hit); end
            if (exp_hit) begin
                total++; if (ifu_inst !== mem_word(pc)) begin
                    bad++; $display("FAIL rand_inst pc=%h got=%h want=%h", pc, ifu_inst, mem_word(pc)); end
            end
            if (inv) begin
                for (int i = 0; i < 16; i++) mv[i] = 1'b0;
                tick();
                ifu_invalid = 1'b0;
            end else if (exp_hit) begin
                tick();
            end else begin
                nmiss++;
                inv_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
                serve_refill({mem_word(line + 12), mem_word(line + 8), mem_word(line + 4), mem_word(line)},
                             inv_beat, int'($urandom_range(0, 2)), a, h, v, t);
                total++; if (t || a !== line || !h || v) begin
                    bad++; $display("FAIL rand_refill pc=%h got=%h/%b/%b/%b want=%h/0/1/0", pc, a, t, h, v, line); end
                if (inv_beat < 0) begin
                    mv[idx] = 1'b1;
                    mt[idx] = pc[31:8];
                end else begin
                    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
                end
            end
        end
        $display("random: 300 fetches, %0d misses", nmiss);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_invalidate();
        test_invalidate_mid_burst();
        test_reset_mid_r();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
